ring_output_arbiter: RTL and testbench
======================================

RING_OUTPUT_ARBITER -- requirements
Module: ring_output_arbiter

Interface
REQ-001 SHALL have parameter NumInputs, default 3, number of requesting input ports (index 0=West, 1=East, 2=Local, matching noc::direction_t bit order).
REQ-002 SHALL have parameter CreditDepth, default 4, downstream input-buffer depth in flits (legal range 1..15).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req_valid  input  NumInputs  per-input flit valid for this output port.
REQ-006 req_head  input  NumInputs  per-input flit is a packet header.
REQ-007 req_tail  input  NumInputs  per-input flit is a packet tail; head and tail both set means a single-flit packet.
REQ-008 credit_in  input  1  one downstream buffer slot freed this cycle.
REQ-009 gnt  output  NumInputs  one-hot or zero; bit i high means input i's flit transfers this cycle.
REQ-010 out_valid  output  1  OR of gnt.
REQ-011 owner  output  $clog2(NumInputs)  index of the locked input; equals last winner when unlocked.
REQ-012 locked  output  1  a multi-flit packet holds the port.
REQ-013 credit_count  output  $clog2(CreditDepth+1)  available downstream credits.
REQ-014 credit_error  output  1  sticky; set on credit_in while credit_count==CreditDepth.

Function
REQ-015 SHALL implement two states: IDLE (locked=0) and LOCKED (locked=1).
REQ-016 gnt SHALL be combinational from current inputs and registered state; a transfer occurs in the same cycle gnt is high, with zero-cycle latency.
REQ-017 gnt SHALL be all-zero whenever credit_count==0.
REQ-018 In IDLE, the eligible set SHALL be inputs with req_valid&req_head; the winner SHALL be the first eligible index searching upward (wrapping) from rr_ptr.
REQ-019 In IDLE, a valid flit without req_head SHALL be ignored and never granted.
REQ-020 IDLE->LOCKED SHALL occur on a grant whose flit has req_tail=0; owner<=winner.
REQ-021 A grant in IDLE with req_tail=1 SHALL leave state IDLE and set rr_ptr<=(winner+1) mod NumInputs.
REQ-022 In LOCKED, gnt[owner] SHALL equal req_valid[owner] (subject to credits); all other bits SHALL be 0 regardless of their requests.
REQ-023 LOCKED->IDLE SHALL occur on a granted owner flit with req_tail=1; rr_ptr<=(owner+1) mod NumInputs.
REQ-024 In LOCKED, req_head on the owner SHALL be ignored; the flit is forwarded as body.
REQ-025 credit_count SHALL decrement on out_valid, increment on credit_in, and stay unchanged when both occur.
REQ-026 credit_in at credit_count==CreditDepth without out_valid SHALL saturate the count and set credit_error.
REQ-027 rr_ptr SHALL change only on packet completion (tail transfer), never on a stalled cycle.
REQ-028 Wrap-around: rr_ptr==NumInputs-1 followed by completion SHALL produce rr_ptr=0.

Reset
REQ-029 On rst assertion, asynchronously: state=IDLE, rr_ptr=0, owner=0, credit_count=CreditDepth, credit_error=0; gnt and out_valid SHALL be 0 while rst is high.
REQ-030 Reset mid-packet SHALL drop the lock with no residual grant after release.
REQ-031 The first active edge after rst deassertion SHALL arbitrate normally.

Verification
REQ-032 After reset, inputs 0,1,2 all present head+tail single flits for 3 cycles -> gnt=001,010,100; then 001 again.
REQ-033 Input 1 sends head, two bodies, and a tail while input 0 continuously requests head -> gnt=010 for 4 cycles, then 001; rr_ptr=2 after input 1's tail.
REQ-034 CreditDepth=4, no credit_in, input 2 streams 6 flits -> 4 grants, then gnt=0 with credit_count=0; one credit_in -> 1 grant on the next cycle.
REQ-035 out_valid and credit_in in the same cycle at credit_count=2 -> credit_count stays 2; credit_in at 4 with no transfer -> credit_error=1, count=4.
REQ-036 rst pulsed while LOCKED on input 0 mid-packet -> locked=0, credit_count=4; after release, input 0 body flit alone -> no grant.
REQ-037 In LOCKED, the owner drops req_valid for 2 cycles while others request -> gnt=0 for those cycles, and the lock is held.

Source files
------------

// File: rtl/ring_output_arbiter_if.sv
// Handshake bundle between the per-input flit sources and one ring output
// port arbiter. The master side drives requests and returned credits; the
// slave side (the arbiter) drives grants and its visible status.
interface ring_output_arbiter_if #(
    parameter int NumInputs   = 3,
    parameter int CreditDepth = 4
);
    localparam int OwnerW = (NumInputs > 1) ? $clog2(NumInputs) : 1;
    localparam int CountW = $clog2(CreditDepth + 1);

    logic [NumInputs-1:0] req_valid;
    logic [NumInputs-1:0] req_head;
    logic [NumInputs-1:0] req_tail;
    logic                 credit_in;

    logic [NumInputs-1:0] gnt;
    logic                 out_valid;
    logic [OwnerW-1:0]    owner;
    logic                 locked;
    logic [CountW-1:0]    credit_count;
    logic                 credit_error;

    modport master (
        output req_valid, req_head, req_tail, credit_in,
        input  gnt, out_valid, owner, locked, credit_count, credit_error
    );

    modport slave (
        input  req_valid, req_head, req_tail, credit_in,
        output gnt, out_valid, owner, locked, credit_count, credit_error
    );
endinterface

// File: rtl/ring_output_arbiter.sv
// Output-port arbiter for a ring router. Packets are granted whole: a header
// wins round-robin arbitration, then the port stays locked to that input
// until its tail flit goes out. Transfers are gated by a downstream credit
// counter, and grants are combinational (zero-cycle latency).
module ring_output_arbiter #(
    parameter int NumInputs   = 3,
    parameter int CreditDepth = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    ring_output_arbiter_if.slave   bus
);
    localparam int OwnerW = (NumInputs > 1) ? $clog2(NumInputs) : 1;
    localparam int CountW = $clog2(CreditDepth + 1);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [OwnerW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [OwnerW-1:0]    owner_q, owner_d;
    logic [CountW-1:0]    credit_q, credit_d;
    logic                 credit_error_q, credit_error_d;

    logic [NumInputs-1:0] eligible;
    logic [NumInputs-1:0] gnt_c;
    logic                 found;
    int                   win;
    int                   idx;

    // Pick the first header-carrying request at or above rr_ptr, wrapping.
    // NOTE: every combinational output gets a default before any branch so
    // no path leaves a value unassigned, which would infer a latch.
    always_comb begin
        eligible = bus.req_valid & bus.req_head;
        found    = 1'b0;
        win      = 0;
        idx      = 0;
        for (int off = 0; off < NumInputs; off++) begin
            idx = (int'(rr_ptr_q) + off) % NumInputs;
            if (!found && eligible[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // Packet-lock FSM: grant decision and next state/pointer/owner.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        gnt_c    = '0;
        // No grant during reset or with no downstream space.
        if (!rst && credit_q != '0) begin
            unique case (state_q)
                IDLE: begin
                    if (found) begin
                        gnt_c[win] = 1'b1;
                        owner_d    = OwnerW'(win);
                        if (bus.req_tail[win]) begin
                            // Single-flit packet: completes immediately.
                            rr_ptr_d = OwnerW'((win + 1) % NumInputs);
                        end else begin
                            state_d = LOCKED;
                        end
                    end
                end
                LOCKED: begin
                    // Owner's head bit is irrelevant here; flit goes as body.
                    if (bus.req_valid[owner_q]) begin
                        gnt_c[owner_q] = 1'b1;
                        if (bus.req_tail[owner_q]) begin
                            state_d  = IDLE;
                            rr_ptr_d = OwnerW'((int'(owner_q) + 1) % NumInputs);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Credit accounting: a transfer spends one slot, credit_in returns one.
    always_comb begin
        credit_d       = credit_q;
        credit_error_d = credit_error_q;
        unique case ({bus.out_valid, bus.credit_in})
            2'b10: credit_d = credit_q - CountW'(1);
            2'b01: begin
                if (credit_q == CountW'(CreditDepth)) begin
                    credit_error_d = 1'b1;
                end else begin
                    credit_d = credit_q + CountW'(1);
                end
            end
            default: ;
        endcase
    end

    // State registers with asynchronous reset to an empty, unlocked port.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            rr_ptr_q       <= '0;
            owner_q        <= '0;
            credit_q       <= CountW'(CreditDepth);
            credit_error_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            owner_q        <= owner_d;
            credit_q       <= credit_d;
            credit_error_q <= credit_error_d;
        end
    end

    assign bus.gnt          = gnt_c;
    assign bus.out_valid    = |gnt_c;
    assign bus.owner        = owner_q;
    assign bus.locked       = (state_q == LOCKED);
    assign bus.credit_count = credit_q;
    assign bus.credit_error = credit_error_q;
endmodule

// File: tb/tb_ring_output_arbiter.sv
// Directed bench for ring_output_arbiter. The stimulus process pushes the
// expected grant vector for each driven cycle; a monitor on the falling edge
// pops and compares it against the DUT. Registered status is checked inline.
module tb_ring_output_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [2:0] gnt;
        string      tag;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;

    ring_output_arbiter_if #(.NumInputs(3), .CreditDepth(4)) bus ();

    ring_output_arbiter #(.NumInputs(3), .CreditDepth(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of requests at posedge+1, queue the expected grant,
    // then advance to just past the next rising edge.
    task automatic step(input logic [2:0] v, input logic [2:0] h, input logic [2:0] t,
                        input logic ci, input logic [2:0] exp_gnt, input string tag);
        exp_t e;
        bus.req_valid = v;
        bus.req_head  = h;
        bus.req_tail  = t;
        bus.credit_in = ci;
        e.gnt = exp_gnt;
        e.tag = tag;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare the combinational grant mid-cycle against the queue;
    // with nothing queued the port must be silent.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            cur = exp_q.pop_front();
            check({cur.tag, "_gnt"}, int'(bus.gnt), int'(cur.gnt));
            check({cur.tag, "_out_valid"}, int'(bus.out_valid), int'(|cur.gnt));
        end else begin
            check("quiet_gnt", int'(bus.gnt), 0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.req_valid = '0;
        bus.req_head  = '0;
        bus.req_tail  = '0;
        bus.credit_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_locked", int'(bus.locked), 0);
        check("rst_owner", int'(bus.owner), 0);
        check("rst_credit", int'(bus.credit_count), 4);
        check("rst_error", int'(bus.credit_error), 0);
        rst = 1'b0;

        // Round robin over single-flit packets from all three inputs.
        step(3'b111, 3'b111, 3'b111, 1'b1, 3'b001, "rr0");
        step(3'b111, 3'b111, 3'b111, 1'b1, 3'b010, "rr1");
        step(3'b111, 3'b111, 3'b111, 1'b1, 3'b100, "rr2");
        step(3'b111, 3'b111, 3'b111, 1'b1, 3'b001, "rr3");
        check("rr_owner", int'(bus.owner), 0);
        check("rr_credit", int'(bus.credit_count), 4);
        step(3'b000, 3'b000, 3'b000, 1'b0, 3'b000, "rr_idle");

        // Input 1 four-flit packet; input 0 keeps offering a header.
        step(3'b011, 3'b011, 3'b001, 1'b1, 3'b010, "pkt_head");
        check("pkt_locked", int'(bus.locked), 1);
        check("pkt_owner", int'(bus.owner), 1);
        step(3'b011, 3'b001, 3'b001, 1'b1, 3'b010, "pkt_body1");
        step(3'b011, 3'b011, 3'b001, 1'b1, 3'b010, "pkt_body2_head_ignored");
        check("pkt_still_locked", int'(bus.locked), 1);
        step(3'b011, 3'b001, 3'b011, 1'b1, 3'b010, "pkt_tail");
        check("pkt_unlocked", int'(bus.locked), 0);
        // rr_ptr must now be 2: input 2 beats input 0.
        step(3'b101, 3'b101, 3'b101, 1'b1, 3'b100, "pkt_rr2");
        step(3'b001, 3'b001, 3'b001, 1'b1, 3'b001, "pkt_then0");

        // Owner stalls for two cycles while others request.
        step(3'b100, 3'b100, 3'b000, 1'b1, 3'b100, "stall_head");
        step(3'b011, 3'b011, 3'b011, 1'b0, 3'b000, "stall1");
        step(3'b011, 3'b011, 3'b011, 1'b0, 3'b000, "stall2");
        check("stall_locked", int'(bus.locked), 1);
        check("stall_owner", int'(bus.owner), 2);
        step(3'b111, 3'b111, 3'b100, 1'b1, 3'b100, "stall_tail");
        check("stall_unlocked", int'(bus.locked), 0);

        // Headerless flit in IDLE is never granted.
        step(3'b001, 3'b000, 3'b000, 1'b0, 3'b000, "idle_body");

        // Credit exhaustion: six offered flits, four granted.
        step(3'b100, 3'b100, 3'b100, 1'b0, 3'b100, "cr1");
        step(3'b100, 3'b100, 3'b100, 1'b0, 3'b100, "cr2");
        step(3'b100, 3'b100, 3'b100, 1'b0, 3'b100, "cr3");
        step(3'b100, 3'b100, 3'b100, 1'b0, 3'b100, "cr4");
        step(3'b100, 3'b100, 3'b100, 1'b0, 3'b000, "cr5");
        step(3'b100, 3'b100, 3'b100, 1'b0, 3'b000, "cr6");
        check("cr_empty", int'(bus.credit_count), 0);
        step(3'b100, 3'b100, 3'b100, 1'b1, 3'b000, "cr_return");
        check("cr_one", int'(bus.credit_count), 1);
        step(3'b100, 3'b100, 3'b100, 1'b0, 3'b100, "cr_regrant");
        step(3'b100, 3'b100, 3'b100, 1'b0, 3'b000, "cr_empty_again");
        check("cr_zero", int'(bus.credit_count), 0);

        // Simultaneous spend and return, then overflow.
        step(3'b000, 3'b000, 3'b000, 1'b1, 3'b000, "ret1");
        step(3'b000, 3'b000, 3'b000, 1'b1, 3'b000, "ret2");
        check("ret_two", int'(bus.credit_count), 2);
        step(3'b001, 3'b001, 3'b001, 1'b1, 3'b001, "both");
        check("both_count", int'(bus.credit_count), 2);
        check("both_no_error", int'(bus.credit_error), 0);
        step(3'b000, 3'b000, 3'b000, 1'b1, 3'b000, "ret3");
        step(3'b000, 3'b000, 3'b000, 1'b1, 3'b000, "ret4");
        check("ret_full", int'(bus.credit_count), 4);
        step(3'b000, 3'b000, 3'b000, 1'b1, 3'b000, "overflow");
        check("overflow_count", int'(bus.credit_count), 4);
        check("overflow_error", int'(bus.credit_error), 1);

        // Reset in the middle of a packet from input 0.
        step(3'b001, 3'b001, 3'b000, 1'b1, 3'b001, "mid_head");
        check("mid_locked", int'(bus.locked), 1);
        step(3'b001, 3'b000, 3'b000, 1'b1, 3'b001, "mid_body");
        bus.credit_in = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_locked", int'(bus.locked), 0);
        check("mid_rst_credit", int'(bus.credit_count), 4);
        check("mid_rst_error", int'(bus.credit_error), 0);
        check("mid_rst_gnt", int'(bus.gnt), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(3'b001, 3'b000, 3'b000, 1'b0, 3'b000, "post_rst_body");
        step(3'b001, 3'b001, 3'b001, 1'b1, 3'b001, "post_rst_pkt");
        check("post_rst_locked", int'(bus.locked), 0);
        check("post_rst_credit", int'(bus.credit_count), 4);

        bus.req_valid = '0;
        bus.credit_in = 1'b0;
        @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
